// File: rtl/hero_bus_arb_if.sv
// Bus bundle for hero_bus_arb: requester side, downstream hero bus, and owner/status.
// With HERO_BUS_ARB_WATCHDOG_EN defined the bundle also carries wdog_err.
interface hero_bus_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned HERO_WIDTH = 36
);
    localparam int unsigned OwnerW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [2*NUM_REQ-1:0]          req_cycle_type;
    logic [HERO_WIDTH*NUM_REQ-1:0] req_wdat;
    logic [NUM_REQ-1:0]            req_gnt;
    logic                          hero_ready;
    logic [1:0]                    hero_cycle_type;
    logic [HERO_WIDTH-1:0]         hero_wdat;
    logic                          hero_clk_en;
    logic [OwnerW-1:0]             owner;
`ifdef HERO_BUS_ARB_WATCHDOG_EN
    logic                          wdog_err;

    modport master (
        output req_valid, req_cycle_type, req_wdat, hero_ready,
        input  req_gnt, hero_cycle_type, hero_wdat, hero_clk_en, owner, wdog_err
    );
    modport slave (
        input  req_valid, req_cycle_type, req_wdat, hero_ready,
        output req_gnt, hero_cycle_type, hero_wdat, hero_clk_en, owner, wdog_err
    );
`else
    modport master (
        output req_valid, req_cycle_type, req_wdat, hero_ready,
        input  req_gnt, hero_cycle_type, hero_wdat, hero_clk_en, owner
    );
    modport slave (
        input  req_valid, req_cycle_type, req_wdat, hero_ready,
        output req_gnt, hero_cycle_type, hero_wdat, hero_clk_en, owner
    );
`endif
endinterface

// File: rtl/hero_bus_arb.sv
// Round-robin burst arbiter onto the hero bus; a VALID beat locks the bus until DONE.
// Optional burst watchdog enabled by defining HERO_BUS_ARB_WATCHDOG_EN.
module hero_bus_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned HERO_WIDTH = 36,
    parameter int unsigned MAX_BURST  = 16
) (
    input logic           clk,
    input logic           rst_n,
    hero_bus_arb_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned SumW = IdxW + 1;

    localparam logic [1:0] CtIdle  = 2'd0;
    localparam logic [1:0] CtValid = 2'd1;
    localparam logic [1:0] CtDone  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 2) begin : g_bad_params
        $error("hero_bus_arb: unsupported parameter values");
    end

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [1:0]            cycle_type_q, cycle_type_d;
    logic [HERO_WIDTH-1:0] wdat_q, wdat_d;
    logic                  clk_en_q, clk_en_d;

    logic [1:0]            req_type [NUM_REQ];
    logic [HERO_WIDTH-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0]    eligible;

    logic                  rr_found;
    logic [IdxW-1:0]       rr_idx;
    logic [SumW-1:0]       rr_sum;

    logic                  grant_ok;
    logic [IdxW-1:0]       gnt_idx;
    logic                  wdog_fire;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        if (i == IdxW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + IdxW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_type[i] = bus.req_cycle_type[2*i +: 2];
            req_data[i] = bus.req_wdat[HERO_WIDTH*i +: HERO_WIDTH];
            eligible[i] = bus.req_valid[i] &&
                          (req_type[i] == CtValid || req_type[i] == CtDone);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = SumW'(rr_ptr_q) + SumW'(k);
            if (rr_sum >= SumW'(NUM_REQ)) begin
                rr_sum = rr_sum - SumW'(NUM_REQ);
            end
            if (!rr_found && eligible[rr_sum[IdxW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[IdxW-1:0];
            end
        end
    end

`ifdef HERO_BUS_ARB_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            wdog_err_q, wdog_err_d;

    assign wdog_fire = (state_q == StBurst) && (burst_cnt_q == CntW'(MAX_BURST - 1));

    always_comb begin
        burst_cnt_d = '0;
        wdog_err_d  = wdog_fire;
        if (state_q == StBurst && state_d == StBurst) begin
            burst_cnt_d = burst_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cycle_type_d = CtIdle;
        wdat_d       = wdat_q;
        clk_en_d     = 1'b0;
        grant_ok     = 1'b0;
        gnt_idx      = owner_q;

        case (state_q)
            StIdle: begin
                gnt_idx  = rr_idx;
                grant_ok = rr_found && bus.hero_ready;
            end
            StBurst: begin
                // Locked: only the owner may move, everyone else stalls.
                grant_ok = eligible[owner_q] && bus.hero_ready && !wdog_fire;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (grant_ok) begin
            cycle_type_d = req_type[gnt_idx];
            wdat_d       = req_data[gnt_idx];
            clk_en_d     = 1'b1;
            owner_d      = gnt_idx;
            if (req_type[gnt_idx] == CtDone) begin
                state_d  = StIdle;
                rr_ptr_d = next_idx(gnt_idx);
            end else begin
                state_d  = StBurst;
            end
        end

        // Watchdog closes the burst with a synthetic DONE carrying zero data.
        if (wdog_fire) begin
            cycle_type_d = CtDone;
            wdat_d       = '0;
            clk_en_d     = 1'b1;
            state_d      = StIdle;
            rr_ptr_d     = next_idx(owner_q);
        end
    end

    always_comb begin
        bus.req_gnt = '0;
        if (grant_ok && rst_n) begin
            bus.req_gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cycle_type_q <= CtIdle;
            wdat_q       <= '0;
            clk_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cycle_type_q <= cycle_type_d;
            wdat_q       <= wdat_d;
            clk_en_q     <= clk_en_d;
        end
    end

    assign bus.hero_cycle_type = cycle_type_q;
    assign bus.hero_wdat       = wdat_q;
    assign bus.hero_clk_en     = clk_en_q;
    assign bus.owner           = owner_q;
endmodule

// File: tb/tb_hero_bus_arb.sv
// Self-checking bench for hero_bus_arb: directed stimulus, expected bus beats queued per cycle.
// Watchdog scenario runs only when HERO_BUS_ARB_WATCHDOG_EN is defined.
module tb_hero_bus_arb;
    localparam int unsigned NReq     = 4;
    localparam int unsigned W        = 36;
    localparam int unsigned MaxBurst = 8;

    localparam logic [1:0] CtIdle  = 2'd0;
    localparam logic [1:0] CtValid = 2'd1;
    localparam logic [1:0] CtDone  = 2'd2;
    localparam logic [1:0] CtBad   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hero_bus_arb_if #(.NUM_REQ(NReq), .HERO_WIDTH(W)) bus ();

    hero_bus_arb #(
        .NUM_REQ   (NReq),
        .HERO_WIDTH(W),
        .MAX_BURST (MaxBurst)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0]   ctype;
        logic [W-1:0] wdat;
        logic         clk_en;
        logic [1:0]   owner;
        logic         werr;
    } bus_exp_t;

    bus_exp_t     sb_q[$];
    logic [W-1:0] hold_wdat = '0;
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [W-1:0] d);
        bus.req_valid[i]             = v;
        bus.req_cycle_type[2*i +: 2] = t;
        bus.req_wdat[W*i +: W]       = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid      = '0;
        bus.req_cycle_type = '0;
        bus.req_wdat       = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".gnt"}, 64'(bus.req_gnt), 64'd0);
        check_eq({tag, ".ctype"}, 64'(bus.hero_cycle_type), 64'd0);
        check_eq({tag, ".wdat"}, 64'(bus.hero_wdat), 64'd0);
        check_eq({tag, ".clk_en"}, 64'(bus.hero_clk_en), 64'd0);
        check_eq({tag, ".owner"}, 64'(bus.owner), 64'd0);
`ifdef HERO_BUS_ARB_WATCHDOG_EN
        check_eq({tag, ".wdog_err"}, 64'(bus.wdog_err), 64'd0);
`endif
    endtask

    // One clock: grant checked mid-cycle, the queued beat checked just after the edge.
    task automatic cycle(input string tag, input logic [NReq-1:0] exp_gnt, input logic [1:0] ctype,
                         input logic [W-1:0] wdat, input logic [1:0] own, input logic werr);
        bus_exp_t e;
        bus_exp_t r;
        @(negedge clk);
        check_eq({tag, ".gnt"}, 64'(bus.req_gnt), 64'(exp_gnt));
        e.ctype  = ctype;
        e.clk_en = (ctype != CtIdle);
        e.wdat   = (ctype != CtIdle) ? wdat : hold_wdat;
        e.owner  = own;
        e.werr   = werr;
        hold_wdat = e.wdat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        r = sb_q.pop_front();
        check_eq({tag, ".ctype"}, 64'(bus.hero_cycle_type), 64'(r.ctype));
        check_eq({tag, ".wdat"}, 64'(bus.hero_wdat), 64'(r.wdat));
        check_eq({tag, ".clk_en"}, 64'(bus.hero_clk_en), 64'(r.clk_en));
        check_eq({tag, ".owner"}, 64'(bus.owner), 64'(r.owner));
`ifdef HERO_BUS_ARB_WATCHDOG_EN
        check_eq({tag, ".wdog_err"}, 64'(bus.wdog_err), 64'(r.werr));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_reqs();
        bus.hero_ready = 1'b1;
        // Reset holds everything at zero, even with a request pending.
        set_req(0, 1'b1, CtDone, 36'h1);
        #12;
        check_all_zero("reset");
        clear_reqs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four requesters issue single-beat DONEs: plain round robin.
        for (int i = 0; i < NReq; i++) set_req(i, 1'b1, CtDone, W'(36'h100 + i));
        cycle("rr0", 4'b0001, CtDone, 36'h100, 2'd0, 1'b0);
        cycle("rr1", 4'b0010, CtDone, 36'h101, 2'd1, 1'b0);
        cycle("rr2", 4'b0100, CtDone, 36'h102, 2'd2, 1'b0);
        cycle("rr3", 4'b1000, CtDone, 36'h103, 2'd3, 1'b0);
        cycle("rr4", 4'b0001, CtDone, 36'h100, 2'd0, 1'b0);
        clear_reqs();
        cycle("rr_idle", 4'b0000, CtIdle, '0, 2'd0, 1'b0);

        // Req1 burst locks out req0 until its DONE is accepted.
        set_req(0, 1'b1, CtDone, 36'hA0);
        set_req(1, 1'b1, CtValid, 36'hB1);
        cycle("lock_v1", 4'b0010, CtValid, 36'hB1, 2'd1, 1'b0);
        set_req(1, 1'b1, CtValid, 36'hB2);
        cycle("lock_v2", 4'b0010, CtValid, 36'hB2, 2'd1, 1'b0);
        set_req(1, 1'b1, CtDone, 36'hB3);
        cycle("lock_done", 4'b0010, CtDone, 36'hB3, 2'd1, 1'b0);
        set_req(1, 1'b0, CtIdle, '0);
        cycle("lock_after", 4'b0001, CtDone, 36'hA0, 2'd0, 1'b0);
        clear_reqs();

        // Backpressure mid-burst; req3 waits behind the lock.
        set_req(2, 1'b1, CtValid, 36'hC1);
        set_req(3, 1'b1, CtDone, 36'hD1);
        cycle("bp_v1", 4'b0100, CtValid, 36'hC1, 2'd2, 1'b0);
        set_req(2, 1'b1, CtValid, 36'hC2);
        cycle("bp_v2", 4'b0100, CtValid, 36'hC2, 2'd2, 1'b0);
        set_req(2, 1'b1, CtValid, 36'hC3);
        bus.hero_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bp_stall", 4'b0000, CtIdle, '0, 2'd2, 1'b0);
        bus.hero_ready = 1'b1;
        cycle("bp_v3", 4'b0100, CtValid, 36'hC3, 2'd2, 1'b0);
        set_req(2, 1'b1, CtDone, 36'hC4);
        cycle("bp_done", 4'b0100, CtDone, 36'hC4, 2'd2, 1'b0);
        set_req(2, 1'b0, CtIdle, '0);
        cycle("bp_next", 4'b1000, CtDone, 36'hD1, 2'd3, 1'b0);
        clear_reqs();

        // Reset mid-burst drops the lock without a DONE.
        set_req(2, 1'b1, CtValid, 36'hE1);
        cycle("rst_v1", 4'b0100, CtValid, 36'hE1, 2'd2, 1'b0);
        set_req(2, 1'b1, CtValid, 36'hE2);
        cycle("rst_v2", 4'b0100, CtValid, 36'hE2, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        hold_wdat = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_rel.ctype", 64'(bus.hero_cycle_type), 64'(CtIdle));
        set_req(1, 1'b1, CtDone, 36'hF1);
        set_req(2, 1'b1, CtDone, 36'hF2);
        cycle("rst_first", 4'b0010, CtDone, 36'hF1, 2'd1, 1'b0);
        clear_reqs();

        // Illegal and IDLE cycle types are never granted.
        set_req(0, 1'b1, CtBad, 36'h333);
        set_req(1, 1'b1, CtIdle, 36'h444);
        for (int i = 0; i < 3; i++) cycle("illegal", 4'b0000, CtIdle, '0, 2'd1, 1'b0);
        clear_reqs();

`ifdef HERO_BUS_ARB_WATCHDOG_EN
        // Req2 never finishes: watchdog forces DONE and passes the bus to req3.
        set_req(2, 1'b1, CtValid, 36'h900);
        cycle("wd_start", 4'b0100, CtValid, 36'h900, 2'd2, 1'b0);
        for (int k = 1; k < MaxBurst; k++) begin
            set_req(2, 1'b1, CtValid, W'(36'h900 + k));
            cycle("wd_beat", 4'b0100, CtValid, W'(36'h900 + k), 2'd2, 1'b0);
        end
        cycle("wd_fire", 4'b0000, CtDone, '0, 2'd2, 1'b1);
        set_req(3, 1'b1, CtDone, 36'hAA3);
        cycle("wd_next", 4'b1000, CtDone, 36'hAA3, 2'd3, 1'b0);
        clear_reqs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
